// File: rtl/mul_div_unit.sv
// ----------------------------------------------------------------------------
// mul_div_unit
//   Iterative radix-2 multiply / multiply-accumulate / divide unit for EX.
//   One shared 2*DATA_W shift register carries the product (multiply) or the
//   {remainder, quotient} pair (divide). Operands are latched as magnitudes
//   with their signs kept aside; the FIX state applies sign correction and
//   the HILO accumulate before the result is registered.
//
//   Optional feature macro: MDU_DIV_EN
//     defined   -> restoring divider built, DIV/DIVU fully supported
//     undefined -> no divide hardware; DIV/DIVU complete in one cycle with
//                  a zero result and div_zero_o low
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   start_i          request a new operation (honoured only in IDLE)
//   annul_i          flush: abandon any operation, suppress result strobe
//   op_i[2:0]        000 MULT 001 MULTU 010 MADD 011 MADDU
//                    100 MSUB 101 MSUBU 110 DIV  111 DIVU
//   opa_i, opb_i     multiplicand/dividend, multiplier/divisor
//   acc_hi_i/lo_i    forwarded HILO for MADD/MSUB
//   hi_o, lo_o       registered result, held until the next result
//   result_valid_o   one-cycle result strobe
//   stall_req_o      pipeline hold request
//   div_zero_o       qualifies result_valid_o: divisor was zero
// ----------------------------------------------------------------------------
module mul_div_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              annul_i,
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] opa_i,
    input  logic [DATA_W-1:0] opb_i,
    input  logic [DATA_W-1:0] acc_hi_i,
    input  logic [DATA_W-1:0] acc_lo_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              result_valid_o,
    output logic              stall_req_o,
    output logic              div_zero_o
);
    localparam int W2 = 2 * DATA_W;

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              sa_q, sa_d, sb_q, sb_d;   // operand signs (signed ops only)
    logic [W2-1:0]     acc_q, acc_d;
    logic [W2-1:0]     prod_q, prod_d;           // product or {rem, quot}
    logic [DATA_W-1:0] mreg_q, mreg_d;           // multiplicand or divisor magnitude
    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
    logic              dzr_q, dzr_d;             // div-by-zero flag of the held result
`ifdef MDU_DIV_EN
    logic              dz_q, dz_d;               // current op is a divide by zero
`endif

    // Operand magnitudes; op_i[0]=0 selects the signed variant of every op.
    logic              in_signed;
    logic [DATA_W-1:0] abs_a, abs_b;
    assign in_signed = ~op_i[0];
    assign abs_a     = (in_signed && opa_i[DATA_W-1]) ? -opa_i : opa_i;
    assign abs_b     = (in_signed && opb_i[DATA_W-1]) ? -opb_i : opb_i;

    // Shift-add step: add multiplicand into the upper half when the
    // multiplier LSB (bottom of prod_q) is set; carry feeds the shift.
    logic [DATA_W:0] mul_sum;
    assign mul_sum = {1'b0, prod_q[W2-1:DATA_W]} + (prod_q[0] ? {1'b0, mreg_q} : '0);

`ifdef MDU_DIV_EN
    // Restoring step: {rem, next dividend bit} is trial-reduced by the divisor.
    logic [DATA_W:0]   div_shl;
    logic              div_ge;
    logic [DATA_W-1:0] div_rem;
    assign div_shl = prod_q[W2-1:DATA_W-1];
    assign div_ge  = div_shl >= {1'b0, mreg_q};
    assign div_rem = div_ge ? DATA_W'(div_shl - {1'b0, mreg_q}) : div_shl[DATA_W-1:0];

    logic [DATA_W-1:0] div_quo_s, div_rem_s;
    assign div_quo_s = (~op_q[0] & (sa_q ^ sb_q)) ? -prod_q[DATA_W-1:0] : prod_q[DATA_W-1:0];
    assign div_rem_s = (~op_q[0] & sa_q) ? -prod_q[W2-1:DATA_W] : prod_q[W2-1:DATA_W];
`endif

    // Sign correction and accumulate, all modulo 2^(2*DATA_W).
    logic [W2-1:0] prod_s, fix_res;
    logic          fix_dz;
    assign prod_s = (~op_q[0] & (sa_q ^ sb_q)) ? -prod_q : prod_q;

    always_comb begin
        fix_res = prod_s;
        fix_dz  = 1'b0;
        case (op_q[2:1])
            2'b01: fix_res = acc_q + prod_s;
            2'b10: fix_res = acc_q - prod_s;
            2'b11: begin
`ifdef MDU_DIV_EN
                if (dz_q) begin
                    fix_res = {prod_q[DATA_W-1:0], {DATA_W{1'b1}}};
                    fix_dz  = 1'b1;
                end else begin
                    fix_res = {div_rem_s, div_quo_s};
                end
`else
                fix_res = '0;
`endif
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        mreg_d  = mreg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dzr_d   = dzr_q;
`ifdef MDU_DIV_EN
        dz_d    = dz_q;
`endif
        if (annul_i) begin
            // Flush wins everywhere; the held result is left untouched.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        op_d  = op_i;
                        sa_d  = in_signed & opa_i[DATA_W-1];
                        sb_d  = in_signed & opb_i[DATA_W-1];
                        acc_d = {acc_hi_i, acc_lo_i};
                        cnt_d = CNT_W'(DATA_W);
`ifdef MDU_DIV_EN
                        dz_d  = 1'b0;
`endif
                        if (op_i[2:1] == 2'b11) begin
`ifdef MDU_DIV_EN
                            if (opb_i == '0) begin
                                // Raw dividend parked in the low half for FIX.
                                dz_d    = 1'b1;
                                prod_d  = {{DATA_W{1'b0}}, opa_i};
                                state_d = S_FIX;
                            end else begin
                                mreg_d  = abs_b;
                                prod_d  = {{DATA_W{1'b0}}, abs_a};
                                state_d = S_ITER;
                            end
`else
                            hi_d    = '0;
                            lo_d    = '0;
                            dzr_d   = 1'b0;
                            state_d = S_DONE;
`endif
                        end else begin
                            mreg_d  = abs_a;
                            prod_d  = {{DATA_W{1'b0}}, abs_b};
                            state_d = S_ITER;
                        end
                    end
                end
                S_ITER: begin
                    cnt_d = cnt_q - 1'b1;
`ifdef MDU_DIV_EN
                    if (op_q[2:1] == 2'b11)
                        prod_d = {div_rem, prod_q[DATA_W-2:0], div_ge};
                    else
                        prod_d = {mul_sum, prod_q[DATA_W-1:1]};
`else
                    prod_d = {mul_sum, prod_q[DATA_W-1:1]};
`endif
                    if (cnt_q == CNT_W'(1))
                        state_d = S_FIX;
                end
                S_FIX: begin
                    hi_d    = fix_res[W2-1:DATA_W];
                    lo_d    = fix_res[DATA_W-1:0];
                    dzr_d   = fix_dz;
                    state_d = S_DONE;
                end
                default: state_d = S_IDLE;   // S_DONE: start here is ignored
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            acc_q   <= '0;
            prod_q  <= '0;
            mreg_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dzr_q   <= 1'b0;
`ifdef MDU_DIV_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            mreg_q  <= mreg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dzr_q   <= dzr_d;
`ifdef MDU_DIV_EN
            dz_q    <= dz_d;
`endif
        end
    end

    assign hi_o           = hi_q;
    assign lo_o           = lo_q;
    // A flush in DONE also swallows the strobe of the result being presented.
    assign result_valid_o = (state_q == S_DONE) && !annul_i;
    assign div_zero_o     = dzr_q && result_valid_o;
    assign stall_req_o    = ((state_q == S_IDLE) && start_i && !annul_i) ||
                            (state_q == S_ITER) || (state_q == S_FIX);

endmodule
